// File: rtl/udp_loopback_buf.sv
// udp_loopback_buf: two-bank ping-pong payload buffer between the UDP receive
// path and the UDP transmit path. Receive fills one bank while the transmitter
// drains the other; banks are filled and drained in strict alternation, so
// frames leave in the order they arrived.
module udp_loopback_buf #(
    parameter int ADDR_W      = 9,
    parameter int MAX_UDP_LEN = 2056
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_o_valid,
    input  logic [31:0]       ram_wr_data,
    input  logic [ADDR_W-1:0] ram_wr_addr,
    input  logic [15:0]       rx_data_length,
    input  logic              data_receive,
    input  logic [ADDR_W-1:0] ram_rd_addr,
    output logic [31:0]       ram_rd_data,
    input  logic              tx_ack,
    input  logic              tx_done,
    output logic              tx_req,
    output logic [15:0]       tx_data_length,
    output logic [15:0]       tx_total_length,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND} rd_state_t;

    // Both banks live in one array; the bank index is the top address bit.
    logic [31:0] mem [0:(2**(ADDR_W+1))-1];

    rd_state_t   state_reg, state_next;
    logic [1:0]  full_reg, full_next;
    logic [15:0] len_reg [2];
    logic        wr_bank_reg, rd_bank_reg;
    logic        in_frame_reg, discard_reg;
    logic [15:0] drop_cnt_reg;
    logic [15:0] tx_len_reg, tx_total_reg;

    logic eff_discard;
    logic wr_en;
    logic len_ok;
    logic commit;
    logic drop;
    logic release_bank;
    logic load_len;

    // A frame with no words yet samples the bank-full flag in the closing cycle;
    // once the first word has arrived the latched decision is used.
    assign eff_discard  = in_frame_reg ? discard_reg : full_reg[wr_bank_reg];
    assign wr_en        = data_o_valid & ~eff_discard;
    assign len_ok       = (rx_data_length >= 16'd8) && (rx_data_length <= 16'(MAX_UDP_LEN));
    assign commit       = data_receive & ~eff_discard & len_ok;
    assign drop         = data_receive & ~commit;
    assign release_bank = (state_reg == R_SEND) & tx_done;
    assign load_len     = (state_reg == R_IDLE) & full_reg[rd_bank_reg];

    // Per-bank full flag: released by the transmitter, claimed by a committed frame.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] = (full_reg[gi] & ~(release_bank && (rd_bank_reg == 1'(gi))))
                                 | (commit && (wr_bank_reg == 1'(gi)));
        end
    endgenerate

    // Payload write into the bank currently owned by the receiver.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank_reg, ram_wr_addr}] <= ram_wr_data;
    end

    // Registered read, always from the bank owned by the transmitter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ram_rd_data <= '0;
        else
            ram_rd_data <= mem[{rd_bank_reg, ram_rd_addr}];
    end

    // Receive-side frame tracking, bank flags, stored lengths and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_reg     <= 2'b00;
            wr_bank_reg  <= 1'b0;
            in_frame_reg <= 1'b0;
            discard_reg  <= 1'b0;
            drop_cnt_reg <= '0;
            for (int i = 0; i < 2; i++)
                len_reg[i] <= '0;
        end else begin
            full_reg <= full_next;
            if (data_receive) begin
                in_frame_reg <= 1'b0;
                discard_reg  <= 1'b0;
            end else if (data_o_valid && !in_frame_reg) begin
                in_frame_reg <= 1'b1;
                discard_reg  <= full_reg[wr_bank_reg];
            end
            if (commit) begin
                len_reg[wr_bank_reg] <= rx_data_length;
                wr_bank_reg          <= ~wr_bank_reg;
            end
            if (drop && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    // Read-side state register, bank pointer and header lengths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= R_IDLE;
            rd_bank_reg  <= 1'b0;
            tx_len_reg   <= '0;
            tx_total_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (release_bank)
                rd_bank_reg <= ~rd_bank_reg;
            if (load_len) begin
                tx_len_reg   <= len_reg[rd_bank_reg];
                tx_total_reg <= len_reg[rd_bank_reg] + 16'd20;
            end
        end
    end

    // Read-side next state and request output.
    always_comb begin
        state_next = state_reg;
        tx_req     = 1'b0;
        case (state_reg)
            R_IDLE: if (full_reg[rd_bank_reg]) state_next = R_REQ;
            R_REQ: begin
                tx_req = 1'b1;
                if (tx_ack) state_next = R_SEND;
            end
            R_SEND: if (tx_done) state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    assign tx_data_length  = tx_len_reg;
    assign tx_total_length = tx_total_reg;
    assign drop_cnt        = drop_cnt_reg;

endmodule

// File: doc/udp_loopback_buf.md
# udp_loopback_buf

Ping-pong payload buffer between the UDP/IP receive path and the UDP/IP transmit path. It captures the 32-bit payload words written by the receiver into one of two 512×32 banks. It latches each frame's UDP length, then presents a completed bank to the transmitter through its read-address and read-data port together with the lengths the transmitter puts in its headers. This allows one frame to be received while the previous one is being sent back.

## Interface
Parameters:
- `ADDR_W`, 9, word address width per bank (512 words = 2048 payload bytes).
- `MAX_UDP_LEN`, 2056, largest accepted UDP length field (8-byte header + 2048 bytes).

Ports:
- `clk`  in  1  Ethernet receive clock; all logic on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `data_o_valid`  in  1  Receive payload word valid.
- `ram_wr_data`  in  32  Receive payload word.
- `ram_wr_addr`  in  ADDR_W  Receive word address, starting at 0 per frame.
- `rx_data_length`  in  16  UDP length field of the current frame; stable when `data_receive` is high.
- `data_receive`  in  1  One-cycle pulse marking the end of a valid frame.
- `ram_rd_addr`  in  ADDR_W  Transmit word read address.
- `ram_rd_data`  out  32  Word from the read bank, registered.
- `tx_ack`  in  1  One-cycle pulse: the transmitter has accepted the request and started the frame.
- `tx_done`  in  1  One-cycle pulse: the transmitter has sent the last byte.
- `tx_req`  out  1  A full bank is ready to send.
- `tx_data_length`  out  16  UDP length for the transmit header.
- `tx_total_length`  out  16  IP total length = `tx_data_length` + 20.
- `drop_cnt`  out  16  Dropped-frame count; saturates at 0xFFFF.

## Operation
Bank state:
- `full[1:0]`, `len0`, `len1` (16 bits each).
- Write pointer `wr_bank`, read pointer `rd_bank`.
- Frame flags `in_frame` and `discard`.

Write side:
- The first `data_o_valid` with `in_frame`=0 sets `in_frame`=1.
  - In that same cycle, `discard` = `full[wr_bank]`.
- Writes: while `in_frame` (including the first word) and `discard`=0, each `data_o_valid` writes `ram_wr_data` to bank `wr_bank` at `ram_wr_addr`.
- On `data_receive`, `in_frame` and `discard` are cleared. Then exactly one of the following applies:
  - `discard`=1: no bank change; `drop_cnt`+1.
  - `rx_data_length` < 8 or > `MAX_UDP_LEN`: no bank change; `drop_cnt`+1. The bank contents are don't-care.
  - Otherwise: `full[wr_bank]`=1 and `len[wr_bank]` = `rx_data_length`. `wr_bank` toggles.
- `data_receive` with no preceding word (zero-payload frame): handled as above with `discard` = `full[wr_bank]` evaluated in that cycle.

Read side state machine (`R_IDLE`, `R_REQ`, `R_SEND`):
- `R_IDLE`: if `full[rd_bank]`, go to `R_REQ`.
- `R_REQ`: `tx_req`=1, with lengths driven from `len[rd_bank]`. On `tx_ack`, go to `R_SEND`.
- `R_SEND`: `tx_req`=0; lengths are held. On `tx_done`: `full[rd_bank]`=0, `rd_bank` toggles, go to `R_IDLE`.
- `tx_ack`/`tx_done` outside their states are ignored.

Read data and lengths:
- `ram_rd_data` is always read from bank `rd_bank`.
- `tx_total_length` = `tx_data_length` + 20, computed in 16 bits. It cannot wrap, because `MAX_UDP_LEN` < 65516.

Banks are written and read strictly in alternation. Frames are therefore returned in arrival order.

## Timing
- Reset (asynchronous, on the assertion of `rst`):
  - `ram_rd_data`=0, `tx_req`=0, `tx_data_length`=0, `tx_total_length`=0, `drop_cnt`=0.
  - `full`=00, `wr_bank`=0, `rd_bank`=0, `in_frame`=0, `discard`=0, state `R_IDLE`.
  - Bank contents are not cleared.
  - A frame or transmission in progress when `rst` asserts is abandoned.
- Read latency: `ram_rd_data` reflects `ram_rd_addr` from the previous edge (1 cycle).
- Write to read: a word written at edge N is readable at edge N+1.
- Frame to request: `data_receive` at edge N sets `full` at N. `R_REQ` is entered at N+1, so `tx_req`=1 after edge N+1 (2-cycle latency). `tx_data_length` is valid from the same cycle.
- Transmit release: `tx_done` at edge M clears `full[rd_bank]` at M. The freed bank can be used by a frame that starts at M+1 or later.
- Simultaneous `data_receive` and `tx_done` in the same cycle: both updates apply.
  - `discard` was latched at frame start, so a bank freed by this `tx_done` is not used retroactively.
- Simultaneous `data_o_valid` and `data_receive`: the word is written (if not discarded) before the frame closes.
- Both banks full: every new frame is discarded until a `tx_done`.

## Test plan
- Single frame:
  - Stimulus: 4 words 0x11111111..0x44444444 at addr 0..3, then `data_receive` with `rx_data_length`=24.
  - Required: `tx_req`=1 two cycles later; `tx_data_length`=24; `tx_total_length`=44. Reading addr 0..3 returns the four words with 1-cycle latency.
- Ping-pong:
  - Stimulus: frame A (len 12) sent, then frame B (len 16) written before `tx_done` of A.
  - Required: B is written to bank 1; after A's `tx_done`, `tx_req` reasserts with length 16 and B's data.
- Overflow:
  - Stimulus: three frames with no `tx_ack`.
  - Required: the third is discarded; `drop_cnt`=1; banks 0 and 1 keep frames 1 and 2 intact.
- Bad length:
  - Stimulus: `rx_data_length`=6, then separately 3000.
  - Required: no `tx_req`; `drop_cnt`=2; `wr_bank` unchanged.
- Simultaneous events:
  - Stimulus: `data_receive` and `tx_done` on the same edge with both banks full minus the receiving one.
  - Required: both full bits are updated correctly; no drop; the next `tx_req` carries the new frame.
- Reset mid-send:
  - Stimulus: assert `rst` asynchronously during `R_SEND`.
  - Required: all outputs go to 0 immediately; after release, `tx_req` stays 0 until a new frame completes.
